// File: rtl/ssm_step_sched.sv
// Per-token sequencer for the SSM state-update datapath.
// Each token runs dAh/dBx in parallel, then h_add, then hC. After hC the
// stages get one release pulse (done_hC). A short gap follows so their level
// dones can drop before the next token starts. Each wait state has a
// watchdog. Start pulses, release and seq_done are decoded from the state,
// so reset forces them low immediately.
//
// Handshake: each *_start is a one-cycle pulse. The matching *_done is a
// level held by the stage until it sees done_hC. A done that is already high
// on entry to a wait state is accepted in that first cycle.
module ssm_step_sched #(
  parameter int LW     = 16,
  parameter int TO_W   = 16,
  parameter int TO_CYC = 4096,
  parameter int GAP    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [LW-1:0] seq_len,
  output logic          dah_start,
  output logic          dbx_start,
  output logic          add_start,
  output logic          hc_start,
  input  logic          dah_done,
  input  logic          dbx_done,
  input  logic          add_done,
  input  logic          hc_done,
  output logic          done_hC,
  output logic          h_sel,
  output logic [LW-1:0] tok_idx,
  output logic          busy,
  output logic          seq_done,
  output logic          err_timeout,
  output logic [3:0]    dbg_state
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ST_A, S_W_A, S_ST_ADD, S_W_ADD, S_ST_Y, S_W_Y,
    S_REL, S_GAP, S_NXT, S_FIN, S_ERR
  } state_t;

  state_t          state, nxt;
  logic [LW-1:0]   len_q;
  logic [TO_W-1:0] wd;
  logic [GW-1:0]   gap_cnt;
  logic            fa, fb;
  logic            in_wait, wd_exp, a_all, b_all;

  assign in_wait   = (state == S_W_A) || (state == S_W_ADD) || (state == S_W_Y);
  assign wd_exp    = (wd == TO_W'(TO_CYC - 1));
  assign a_all     = fa | dah_done;
  assign b_all     = fb | dbx_done;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state and pulse outputs; wait exits take priority over the watchdog
  always_comb begin
    nxt       = state;
    dah_start = 1'b0;
    dbx_start = 1'b0;
    add_start = 1'b0;
    hc_start  = 1'b0;
    done_hC   = 1'b0;
    seq_done  = 1'b0;
    case (state)
      S_IDLE:   if (run) nxt = (seq_len == '0) ? S_FIN : S_ST_A;
      S_ST_A: begin
        dah_start = 1'b1;
        dbx_start = 1'b1;
        nxt       = S_W_A;
      end
      S_W_A: begin
        if (a_all && b_all) nxt = S_ST_ADD;
        else if (wd_exp)    nxt = S_ERR;
      end
      S_ST_ADD: begin
        add_start = 1'b1;
        nxt       = S_W_ADD;
      end
      S_W_ADD: begin
        if (add_done)    nxt = S_ST_Y;
        else if (wd_exp) nxt = S_ERR;
      end
      S_ST_Y: begin
        hc_start = 1'b1;
        nxt      = S_W_Y;
      end
      S_W_Y: begin
        if (hc_done)     nxt = S_REL;
        else if (wd_exp) nxt = S_ERR;
      end
      S_REL: begin
        done_hC = 1'b1;
        nxt     = S_GAP;
      end
      S_GAP:    if (gap_cnt == GW'(GAP - 1)) nxt = S_NXT;
      S_NXT:    nxt = ((tok_idx + LW'(1)) == len_q) ? S_FIN : S_ST_A;
      S_FIN: begin
        seq_done = 1'b1;
        nxt      = S_IDLE;
      end
      S_ERR: begin
        done_hC = 1'b1;
        nxt     = S_IDLE;
      end
      default:  nxt = S_IDLE;
    endcase
  end

  // Sequence bookkeeping: length latch, token index, bank select, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      tok_idx     <= '0;
      h_sel       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (state == S_IDLE && run) begin
        len_q       <= seq_len;
        tok_idx     <= '0;
        h_sel       <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (state == S_NXT) begin
        tok_idx <= tok_idx + LW'(1);
        h_sel   <= ~h_sel;
      end
      if (nxt == S_ERR) err_timeout <= 1'b1;
    end
  end

  // Watchdog, gap counter and sticky dAh/dBx done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd      <= '0;
      gap_cnt <= '0;
      fa      <= 1'b0;
      fb      <= 1'b0;
    end else begin
      wd      <= in_wait ? wd + TO_W'(1) : '0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (state == S_W_A) begin
        fa <= fa | dah_done;
        fb <= fb | dbx_done;
      end else begin
        fa <= 1'b0;
        fb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ssm_step_sched.sv
// Bench for ssm_step_sched. A behavioural stage model answers the start
// pulses. The driver pushes the expected event stream into exp_q. The
// monitor logs DUT events at negedge and compares each one to the next
// entry. An event word holds the kind, tok_idx, h_sel and the cycle delta
// from the previous logged event.
module tb_ssm_step_sched;

  localparam logic [3:0] K_RUN = 4'd1, K_A = 4'd2, K_ADD = 4'd3, K_HC = 4'd4,
                         K_REL = 4'd5, K_SEQ = 4'd6, K_APART = 4'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] seq_len;
  logic        dah_start, dbx_start, add_start, hc_start;
  logic [3:0]  dn;
  logic        done_hC, h_sel, busy, seq_done, err_timeout;
  logic [15:0] tok_idx;
  logic [3:0]  dbg_state;

  logic [31:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_ev = 0;
  int          busy_cnt = 0;
  int          dly[4];
  int          cnt[4];
  int          hold = 0;
  int          rel_cnt = 0;

  ssm_step_sched #(.LW(16), .TO_W(16), .TO_CYC(64), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .seq_len(seq_len),
    .dah_start(dah_start), .dbx_start(dbx_start), .add_start(add_start),
    .hc_start(hc_start), .dah_done(dn[0]), .dbx_done(dn[1]), .add_done(dn[2]),
    .hc_done(dn[3]), .done_hC(done_hC), .h_sel(h_sel), .tok_idx(tok_idx),
    .busy(busy), .seq_done(seq_done), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_ev(input logic [3:0] k, input logic [7:0] t,
                                        input logic h, input logic [15:0] d);
    return {k, t, 3'b000, h, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stage model: done rises dly cycles after start (0 = never) and drops
  // hold+1 cycles after the release pulse
  initial begin
    dn = 4'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; dly[i] = 1; end
    forever begin
      @(posedge clk); #1;
      if (rst_n !== 1'b1) begin
        dn = 4'b0;
        rel_cnt = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
      end else begin
        if (rel_cnt > 0) begin
          rel_cnt--;
          if (rel_cnt == 0) dn = 4'b0;
        end
        for (int i = 0; i < 4; i++)
          if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) dn[i] = 1'b1;
          end
        if (dah_start) cnt[0] = dly[0];
        if (dbx_start) cnt[1] = dly[1];
        if (add_start) cnt[2] = dly[2];
        if (hc_start)  cnt[3] = dly[3];
        if (done_hC)   rel_cnt = hold + 1;
      end
    end
  end

  task automatic log_ev(input logic [3:0] k);
    logic [31:0] act;
    int d;
    d = (k == K_RUN) ? 0 : cyc - last_ev;
    last_ev = cyc;
    act = (k == K_RUN) ? mk_ev(k, 8'd0, 1'b0, 16'd0) : mk_ev(k, tok_idx[7:0], h_sel, 16'(d));
    if (exp_q.size() == 0) chk("unexpected_event", act, 32'h0);
    else chk("event", act, exp_q.pop_front());
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
        if (busy) busy_cnt++;
        if (run) log_ev(K_RUN);
        if (dah_start || dbx_start) begin
          chk("dones_low_at_start", {28'd0, dn}, 32'd0);
          log_ev((dah_start && dbx_start) ? K_A : K_APART);
        end
        if (add_start) log_ev(K_ADD);
        if (hc_start)  log_ev(K_HC);
        if (done_hC)   log_ev(K_REL);
        if (seq_done)  log_ev(K_SEQ);
      end
    end
  end

  // Driver tasks
  task automatic set_stage(input int da, input int db, input int dd, input int dy, input int h);
    dly[0] = da; dly[1] = db; dly[2] = dd; dly[3] = dy; hold = h;
  endtask

  task automatic start_seq(input logic [15:0] len);
    @(posedge clk); #1;
    run = 1'b1;
    seq_len = len;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  // One token: A lands first_d after the previous event; ADD follows the later
  // of the two dones by one cycle; HC and REL follow their dones by one cycle
  task automatic push_token(input int t, input int first_d);
    int mx;
    mx = (dly[0] > dly[1]) ? dly[0] : dly[1];
    exp_q.push_back(mk_ev(K_A, 8'(t), t[0], 16'(first_d)));
    exp_q.push_back(mk_ev(K_ADD, 8'(t), t[0], 16'(mx + 1)));
    exp_q.push_back(mk_ev(K_HC, 8'(t), t[0], 16'(dly[2] + 1)));
    exp_q.push_back(mk_ev(K_REL, 8'(t), t[0], 16'(dly[3] + 1)));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d events pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic end_checks(input string name, input int exp_busy, input logic exp_err);
    chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({name, "_err_timeout"}, {31'd0, err_timeout}, {31'd0, exp_err});
    busy_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    seq_len = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {24'd0, dah_start, dbx_start, add_start, hc_start, done_hC,
        h_sel, seq_done, err_timeout}, 32'd0);
    chk("reset_tok_busy", {15'd0, busy, tok_idx}, 32'd0);
    rst_n = 1'b1;
    busy_cnt = 0;

    // Three tokens, every stage answers 10 cycles after its start
    set_stage(10, 10, 10, 10, 0);
    exp_q.push_back(mk_ev(K_RUN, 8'd0, 1'b0, 16'd0));
    push_token(0, 1);
    push_token(1, 4);
    push_token(2, 4);
    exp_q.push_back(mk_ev(K_SEQ, 8'd3, 1'b1, 16'd4));
    start_seq(16'd3);
    wait_drain("three_tok");
    end_checks("three_tok", 112, 1'b0);
    chk("tok_idx_hold", {16'd0, tok_idx}, 32'd3);

    // dBx early, dAh late: add_start only after the later done
    set_stage(20, 4, 1, 1, 0);
    exp_q.push_back(mk_ev(K_RUN, 8'd0, 1'b0, 16'd0));
    push_token(0, 1);
    exp_q.push_back(mk_ev(K_SEQ, 8'd1, 1'b1, 16'd4));
    start_seq(16'd1);
    wait_drain("dbx_first");
    end_checks("dbx_first", 30, 1'b0);

    // dAh early, dBx late
    set_stage(4, 20, 1, 1, 0);
    exp_q.push_back(mk_ev(K_RUN, 8'd0, 1'b0, 16'd0));
    push_token(0, 1);
    exp_q.push_back(mk_ev(K_SEQ, 8'd1, 1'b1, 16'd4));
    start_seq(16'd1);
    wait_drain("dah_first");
    end_checks("dah_first", 30, 1'b0);

    // Zero-length sequence: straight to FIN, no starts
    exp_q.push_back(mk_ev(K_RUN, 8'd0, 1'b0, 16'd0));
    exp_q.push_back(mk_ev(K_SEQ, 8'd0, 1'b0, 16'd1));
    start_seq(16'd0);
    wait_drain("zero_len");
    end_checks("zero_len", 1, 1'b0);

    // hC never answers: 64 cycles in W_Y, then ERR with one release
    set_stage(1, 1, 1, 0, 0);
    exp_q.push_back(mk_ev(K_RUN, 8'd0, 1'b0, 16'd0));
    exp_q.push_back(mk_ev(K_A, 8'd0, 1'b0, 16'd1));
    exp_q.push_back(mk_ev(K_ADD, 8'd0, 1'b0, 16'd2));
    exp_q.push_back(mk_ev(K_HC, 8'd0, 1'b0, 16'd2));
    exp_q.push_back(mk_ev(K_REL, 8'd0, 1'b0, 16'd65));
    start_seq(16'd1);
    wait_drain("timeout");
    end_checks("timeout", 70, 1'b1);

    // Dones held 2 cycles past release; run while busy ignored
    set_stage(3, 3, 3, 3, 2);
    exp_q.push_back(mk_ev(K_RUN, 8'd0, 1'b0, 16'd0));
    exp_q.push_back(mk_ev(K_A, 8'd0, 1'b0, 16'd1));
    exp_q.push_back(mk_ev(K_RUN, 8'd0, 1'b0, 16'd0));
    exp_q.push_back(mk_ev(K_ADD, 8'd0, 1'b0, 16'd2));
    exp_q.push_back(mk_ev(K_HC, 8'd0, 1'b0, 16'd4));
    exp_q.push_back(mk_ev(K_REL, 8'd0, 1'b0, 16'd4));
    push_token(1, 4);
    exp_q.push_back(mk_ev(K_SEQ, 8'd2, 1'b0, 16'd4));
    start_seq(16'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    run = 1'b1;
    seq_len = 16'd5;
    @(posedge clk); #1;
    run = 1'b0;
    wait_drain("hold_done");
    end_checks("hold_done", 33, 1'b0);

    // Reset while waiting in W_ADD aborts at once
    set_stage(1, 1, 30, 1, 0);
    exp_q.push_back(mk_ev(K_RUN, 8'd0, 1'b0, 16'd0));
    exp_q.push_back(mk_ev(K_A, 8'd0, 1'b0, 16'd1));
    exp_q.push_back(mk_ev(K_ADD, 8'd0, 1'b0, 16'd2));
    start_seq(16'd1);
    wait_drain("abort_pre");
    chk("in_w_add", {28'd0, dbg_state}, 32'd4);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {24'd0, dah_start, dbx_start, add_start, hc_start,
        done_hC, h_sel, seq_done, err_timeout}, 32'd0);
    chk("async_reset_tok_busy", {15'd0, busy, tok_idx}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    busy_cnt = 0;
    set_stage(1, 1, 1, 1, 0);
    exp_q.push_back(mk_ev(K_RUN, 8'd0, 1'b0, 16'd0));
    push_token(0, 1);
    exp_q.push_back(mk_ev(K_SEQ, 8'd1, 1'b1, 16'd4));
    start_seq(16'd1);
    wait_drain("after_reset");
    end_checks("after_reset", 11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
